// File: rtl/demux_sched_pkg.sv
// Shared types, constants and the round-robin lane search for the demux_1x8_sched block.
package demux_sched_pkg;

  localparam int NL_C  = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // First enabled lane at or after ptr, searching upward with wrap; returns ptr when mask is empty.
  function automatic logic [SEL_W-1:0] next_rr(input logic [SEL_W-1:0] ptr,
                                               input logic [NL_C-1:0]  mask);
    logic [SEL_W-1:0] idx;
    next_rr = ptr;
    for (int k = NL_C - 1; k >= 0; k--) begin
      idx = ptr + k[SEL_W-1:0];
      if (mask[idx]) next_rr = idx;
    end
  endfunction

endpackage

// File: rtl/demux_1x8_onehot.sv
// Combinational 3-bit lane select plus enable to 8-bit one-hot lane vector.
module demux_1x8_onehot
  import demux_sched_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [NL_C-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/demux_1x8_sched.sv
// 1-to-8 demux sequencer: one registered output slot steered round-robin or by in_sel.
// Optional per-lane transfer counters are built when DEMUX_SCHED_STATS_EN is defined.
module demux_1x8_sched
  import demux_sched_pkg::*;
#(
  parameter int DW = 8,
  parameter int NL = NL_C
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_mode,
  input  logic [NL-1:0]    cfg_lane_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic [SEL_W-1:0] in_sel,
  output logic [NL-1:0]    out_valid,
  input  logic [NL-1:0]    out_ready,
  output logic [DW-1:0]    out_data,
  output logic             drop_pulse,
  output logic             busy
`ifdef DEMUX_SCHED_STATS_EN
  ,
  output logic [NL*16-1:0] lane_cnt
`endif
);

  // Handshake: a word moves when valid & ready are both high on a rising edge; valid never
  // depends on ready, and a held out_valid/out_data pair stays frozen until its lane is ready.

  state_t           state;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] tgt;
  logic             tgt_en;
  logic             held_done;
  logic             accept;
  logic             load;
  logic [NL-1:0]    tgt_onehot;

  assign held_done = |(out_valid & out_ready);
  assign tgt       = cfg_mode ? in_sel : next_rr(rr_ptr, cfg_lane_en);
  assign tgt_en    = cfg_lane_en[tgt];
  assign accept    = in_valid & in_ready;
  assign load      = accept & tgt_en;
  assign busy      = (state == HOLD);

  // HOLD only reopens on the completing cycle so a new word can replace the old without a bubble.
  always_comb begin
    in_ready = 1'b0;
    unique case (state)
      IDLE:    in_ready = cfg_mode | (|cfg_lane_en);
      HOLD:    in_ready = held_done;
      default: in_ready = 1'b0;
    endcase
  end

  demux_1x8_onehot u_onehot (
    .sel    (tgt),
    .en     (tgt_en),
    .onehot (tgt_onehot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      out_valid  <= '0;
      out_data   <= '0;
      rr_ptr     <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= accept & cfg_mode & ~tgt_en;
      if (load) begin
        out_data  <= in_data;
        out_valid <= tgt_onehot;
        state     <= HOLD;
        if (!cfg_mode) rr_ptr <= tgt + SEL_W'(1);
      end else if ((state == HOLD) && held_done) begin
        out_valid <= '0;
        state     <= IDLE;
      end
    end
  end

`ifdef DEMUX_SCHED_STATS_EN
  logic [15:0] cnt_q [NL];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NL; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NL; i++) begin
        if (out_valid[i] & out_ready[i]) cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < NL; g++) begin : g_cnt_out
    assign lane_cnt[g*16 +: 16] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_demux_1x8_sched.sv
// Self-checking bench for demux_1x8_sched: directed scenarios plus randomized traffic vs a lane model.
module tb_demux_1x8_sched;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_mode;
  logic [7:0]    cfg_lane_en;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [2:0]    in_sel;
  logic [7:0]    out_valid;
  logic [7:0]    out_ready;
  logic [DW-1:0] out_data;
  logic          drop_pulse;
  logic          busy;
`ifdef DEMUX_SCHED_STATS_EN
  logic [127:0]  lane_cnt;
`endif

  always #5 clk = ~clk;

  demux_1x8_sched #(.DW(DW), .NL(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_mode    (cfg_mode),
    .cfg_lane_en (cfg_lane_en),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_sel      (in_sel),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .drop_pulse  (drop_pulse),
    .busy        (busy)
`ifdef DEMUX_SCHED_STATS_EN
    ,
    .lane_cnt    (lane_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard entries are {lane, data}.
  logic [DW+2:0] exp_q[$];

  // Reference model: which lane holds a word (-1 = none), its data, the round-robin pointer.
  int            m_lane = -1;
  logic [DW-1:0] m_data = '0;
  int            m_rr   = 0;
  bit            m_drop = 1'b0;

  function automatic int ref_target();
    if (cfg_mode) return int'(in_sel);
    for (int k = 0; k < 8; k++) begin
      if (cfg_lane_en[(m_rr + k) % 8]) return (m_rr + k) % 8;
    end
    return m_rr;
  endfunction

  function automatic bit ref_ready();
    if (m_lane < 0) return cfg_mode || (cfg_lane_en != 8'h00);
    return out_ready[m_lane];
  endfunction

  function automatic logic [7:0] lane_bit(input int l);
    logic [7:0] v;
    v = 8'h00;
    if (l >= 0) v[l] = 1'b1;
    return v;
  endfunction

  task automatic model_step();
    bit acc;
    int tgt;
    acc    = in_valid && ref_ready();
    tgt    = ref_target();
    m_drop = 1'b0;
    if (m_lane >= 0 && out_ready[m_lane]) m_lane = -1;
    if (acc) begin
      if (cfg_lane_en[tgt]) begin
        m_lane = tgt;
        m_data = in_data;
        if (!cfg_mode) m_rr = (tgt + 1) % 8;
      end else if (cfg_mode) begin
        m_drop = 1'b1;
      end
    end
  endtask

  task automatic drive(input bit mode, input logic [7:0] mask, input bit v,
                       input logic [DW-1:0] d, input logic [2:0] s, input logic [7:0] rdy);
    cfg_mode    = mode;
    cfg_lane_en = mask;
    in_valid    = v;
    in_data     = d;
    in_sel      = s;
    out_ready   = rdy;
  endtask

  // Advance one clock: update the model from the settled inputs, then sample #1 after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 8'hFF, 1'b0, '0, 3'd0, 8'hFF);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    m_lane = -1;
    m_data = '0;
    m_rr   = 0;
    m_drop = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (out_valid !== 8'h00) begin n_fail++; $display("FAIL reset_out_valid: got %h expected %h", out_valid, 8'h00); end
    n_checks++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h expected %h", out_data, 8'h00); end
    n_checks++; if (drop_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %b expected 0", drop_pulse); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_rr_full();
    logic [DW-1:0] d [10];
    logic [DW+2:0] e;
    for (int i = 0; i < 10; i++) begin
      d[i] = DW'($urandom_range(0, 255));
      exp_q.push_back({3'(i % 8), d[i]});
    end
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (c < 10) drive(1'b0, 8'hFF, 1'b1, d[c], 3'd0, 8'hFF);
      else        drive(1'b0, 8'hFF, 1'b0, '0, 3'd0, 8'hFF);
      #1;
      if (c < 10) begin
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rr_full_in_ready[%0d]: got %b expected 1", c, in_ready); end
      end
      tick();
      if (c < 10) begin
        e = exp_q.pop_front();
        n_checks++; if (out_valid !== lane_bit(int'(e[DW+2:DW]))) begin n_fail++; $display("FAIL rr_full_lane[%0d]: got %h expected %h", c, out_valid, lane_bit(int'(e[DW+2:DW]))); end
        n_checks++; if (out_data !== e[DW-1:0]) begin n_fail++; $display("FAIL rr_full_data[%0d]: got %h expected %h", c, out_data, e[DW-1:0]); end
      end else begin
        n_checks++; if (out_valid !== 8'h00) begin n_fail++; $display("FAIL rr_full_drain: got %h expected 00", out_valid); end
      end
    end
  endtask

  task automatic test_rr_mask();
    int lanes [4] = '{2, 5, 7, 2};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b0, 8'b1010_0100, 1'b1, DW'(8'h40 + i), 3'd0, 8'hFF);
      #1;
      tick();
      n_checks++; if (out_valid !== lane_bit(lanes[i])) begin n_fail++; $display("FAIL rr_mask_lane[%0d]: got %h expected %h", i, out_valid, lane_bit(lanes[i])); end
    end
    @(negedge clk);
    drive(1'b0, 8'b1010_0100, 1'b0, '0, 3'd0, 8'hFF);
    #1;
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b0, 8'h00, 1'b1, 8'h77, 3'd0, 8'hFF);
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rr_mask0_in_ready[%0d]: got %b expected 0", i, in_ready); end
      tick();
      n_checks++; if (out_valid !== 8'h00) begin n_fail++; $display("FAIL rr_mask0_valid[%0d]: got %h expected 00", i, out_valid); end
    end
  endtask

  task automatic test_directed_stall();
    @(negedge clk);
    drive(1'b1, 8'hFF, 1'b1, 8'hA5, 3'd3, 8'hF7);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_first_ready: got %b expected 1", in_ready); end
    tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (out_valid !== 8'h08) begin n_fail++; $display("FAIL stall_valid[%0d]: got %h expected 08", i, out_valid); end
      n_checks++; if (out_data !== 8'hA5) begin n_fail++; $display("FAIL stall_data[%0d]: got %h expected a5", i, out_data); end
      @(negedge clk);
      drive(1'b1, 8'hFF, 1'b1, 8'h3C, 3'd5, 8'hF7);
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready[%0d]: got %b expected 0", i, in_ready); end
      tick();
    end
    @(negedge clk);
    drive(1'b1, 8'hFF, 1'b1, 8'h3C, 3'd5, 8'hFF);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready: got %b expected 1", in_ready); end
    tick();
    n_checks++; if (out_valid !== 8'h20) begin n_fail++; $display("FAIL stall_b2b_valid: got %h expected 20", out_valid); end
    n_checks++; if (out_data !== 8'h3C) begin n_fail++; $display("FAIL stall_b2b_data: got %h expected 3c", out_data); end
    @(negedge clk);
    drive(1'b1, 8'hFF, 1'b0, '0, 3'd0, 8'hFF);
    #1;
    tick();
    n_checks++; if (out_valid !== 8'h00) begin n_fail++; $display("FAIL stall_drain: got %h expected 00", out_valid); end
  endtask

  task automatic test_drop();
    @(negedge clk);
    drive(1'b1, 8'hBF, 1'b1, 8'h66, 3'd6, 8'hFF);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL drop_in_ready: got %b expected 1", in_ready); end
    tick();
    n_checks++; if (drop_pulse !== 1'b1) begin n_fail++; $display("FAIL drop_pulse_high: got %b expected 1", drop_pulse); end
    n_checks++; if (out_valid !== 8'h00) begin n_fail++; $display("FAIL drop_valid: got %h expected 00", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_busy: got %b expected 0", busy); end
    @(negedge clk);
    drive(1'b1, 8'hBF, 1'b0, '0, 3'd6, 8'hFF);
    #1;
    tick();
    n_checks++; if (drop_pulse !== 1'b0) begin n_fail++; $display("FAIL drop_pulse_low: got %b expected 0", drop_pulse); end
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge clk);
    drive(1'b0, 8'hFF, 1'b1, 8'h11, 3'd0, 8'hFF);
    #1;
    tick();
    @(negedge clk);
    drive(1'b0, 8'hFF, 1'b1, 8'h22, 3'd0, 8'h01);
    #1;
    tick();
    n_checks++; if (out_valid !== 8'h02) begin n_fail++; $display("FAIL areset_pre_valid: got %h expected 02", out_valid); end
    @(negedge clk);
    drive(1'b0, 8'hFF, 1'b0, '0, 3'd0, 8'h00);
    #1;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 8'h00) begin n_fail++; $display("FAIL areset_valid: got %h expected 00", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy: got %b expected 0", busy); end
    @(negedge clk);
    rst_n  = 1'b1;
    m_lane = -1;
    m_rr   = 0;
    m_drop = 1'b0;
    @(negedge clk);
    drive(1'b0, 8'hFF, 1'b1, 8'h33, 3'd0, 8'hFF);
    #1;
    tick();
    n_checks++; if (out_valid !== 8'h01) begin n_fail++; $display("FAIL areset_first_lane: got %h expected 01", out_valid); end
    @(negedge clk);
    drive(1'b0, 8'hFF, 1'b0, '0, 3'd0, 8'hFF);
    #1;
    tick();
  endtask

  task automatic test_random();
    logic [7:0] mask;
    int         r;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      r = $urandom_range(0, 9);
      if (r == 0)      mask = 8'h00;
      else if (r == 1) mask = 8'hFF;
      else             mask = 8'($urandom_range(0, 255));
      drive(1'($urandom_range(0, 1)), mask, ($urandom_range(0, 9) < 7),
            DW'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      #1;
      n_checks++; if (in_ready !== ref_ready()) begin n_fail++; $display("FAIL rand_in_ready[%0d]: got %b expected %b", c, in_ready, ref_ready()); end
      tick();
      n_checks++; if (out_valid !== lane_bit(m_lane)) begin n_fail++; $display("FAIL rand_valid[%0d]: got %h expected %h", c, out_valid, lane_bit(m_lane)); end
      if (m_lane >= 0) begin
        n_checks++; if (out_data !== m_data) begin n_fail++; $display("FAIL rand_data[%0d]: got %h expected %h", c, out_data, m_data); end
      end
      n_checks++; if (drop_pulse !== m_drop) begin n_fail++; $display("FAIL rand_drop[%0d]: got %b expected %b", c, drop_pulse, m_drop); end
      n_checks++; if (busy !== (m_lane >= 0)) begin n_fail++; $display("FAIL rand_busy[%0d]: got %b expected %b", c, busy, (m_lane >= 0)); end
    end
  endtask

`ifdef DEMUX_SCHED_STATS_EN
  task automatic test_stats();
    logic [15:0] want;
    do_reset();
    @(negedge clk);
    drive(1'b1, 8'hFF, 1'b1, 8'h5A, 3'd1, 8'hFF);
    repeat (70000) @(posedge clk);
    @(negedge clk);
    drive(1'b1, 8'hFF, 1'b0, '0, 3'd1, 8'hFF);
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      want = (i == 1) ? 16'(70000 % 65536) : 16'd0;
      n_checks++; if (lane_cnt[i*16 +: 16] !== want) begin n_fail++; $display("FAIL stats_cnt[%0d]: got %0d expected %0d", i, lane_cnt[i*16 +: 16], want); end
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 8'hFF, 1'b0, '0, 3'd0, 8'hFF);
    test_reset();
    test_rr_full();
    test_rr_mask();
    test_directed_stall();
    test_drop();
    test_async_reset();
    test_random();
`ifdef DEMUX_SCHED_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_1x8_sched.md
Name: demux_1x8_sched

Overview:
- Sequencing controller for a 1-to-8 demultiplexer: accepts one input word stream and steers each word to one of 8 output lanes.
- Each input and output uses a valid/ready handshake.
- Lane choice is round-robin over enabled lanes, or directed by a per-word select.
- Sits between a single producer and eight consumers; the one-hot select decode is isolated in a sub-module.

Parameters:
- DW, 8, data width of input word and shared output data bus.
- NL, 8, lane count; fixed at 8, because select width is 3 bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- cfg_mode  input  1  0 = round-robin, 1 = directed
- cfg_lane_en  input  8  lane enable mask
- in_valid  input  1  input word valid
- in_ready  output  1  block can take input word
- in_data  input  DW  input word
- in_sel  input  3  target lane in directed mode; ignored in round-robin
- out_valid  output  8  one-hot; bit i = lane i holds valid data
- out_ready  input  8  per-lane ready
- out_data  output  DW  shared data to all lanes
- drop_pulse  output  1  1-cycle pulse: directed word discarded (lane disabled)
- busy  output  1  high while state is HOLD

Behaviour:
- Reset (async assert, sync release) sets:
  - state = IDLE
  - out_valid = 0, out_data = 0
  - rr_ptr = 0
  - drop_pulse = 0
- States:
  - IDLE: output register empty.
  - HOLD: one word registered, waiting on its lane.
- Target lane (combinational, from current inputs):
  - Round-robin: first enabled lane at or after rr_ptr, searching upward with wrap 7->0.
  - Directed: in_sel.
- in_ready:
  - IDLE: 1, except 0 in round-robin mode when cfg_lane_en == 0.
  - HOLD: 1 only when the held word completes this cycle (out_valid & out_ready != 0), allowing back-to-back transfer with no bubble.
- Input accept = in_valid & in_ready.
  - If the target lane is enabled: out_data <= in_data; out_valid <= onehot(target); state <= HOLD.
  - Round-robin only: rr_ptr <= target + 1 (mod 8).
- Directed accept to a disabled lane:
  - Word is consumed, nothing is registered.
  - drop_pulse = 1 next cycle; state and rr_ptr unchanged.
  - If this coincides with completion in HOLD, state -> IDLE.
- HOLD completion: when out_ready[held lane] = 1, the transfer completes.
  - If a new word is accepted the same cycle, stay in HOLD and reload.
  - Otherwise go to IDLE and clear out_valid.
- Latency: 1 cycle from input accept to out_valid.
- Throughput: 1 word/cycle if the consumer is always ready.
- out_valid and out_data stay stable in HOLD until completion.
- cfg_lane_en / cfg_mode changes:
  - Sampled only at input accept; never retarget a held word.
  - Clearing the held lane's enable while in HOLD does not abort it.
- out_ready on lanes without out_valid is ignored.
- At most one out_valid bit is high at any time.
- Reset mid-HOLD discards the held word.

Optional Feature:
- Macro: DEMUX_SCHED_STATS_EN.
- Defined: adds output lane_cnt (8x16 bits, flattened 128), one wrapping 16-bit counter per lane.
  - Counter increments on each completed transfer on that lane.
  - Counters reset to 0 on rst_n.
  - 16'hFFFF wraps to 0.
- Undefined: no port, no counters; all other behaviour identical.

Decomposition:
- Package demux_sched_pkg holds:
  - state enum (IDLE=1'b0, HOLD=1'b1)
  - NL_C = 8 and SEL_W = 3
  - function next_rr(ptr, mask) returning the 3-bit target
- Sub-module: demux_1x8_onehot, a combinational 3-bit select plus enable -> 8-bit one-hot.
  - Used to build out_valid.

Test Plan:
- Round-robin, mask 8'hFF, all ready, 10 words: lanes 0,1,...,7,0,1.
  - in_ready held 1; one word per cycle; out_valid one cycle after each accept.
- Round-robin, mask 8'b1010_0100, rr_ptr=0, 4 words: lanes 2,5,7,2.
  - Mask 0: in_ready=0, no out_valid.
- Directed: in_sel=3 with out_ready[3]=0 for 5 cycles.
  - out_valid=8'h08 with data stable, in_ready=0.
  - Raise ready: transfer completes; next word is accepted in the same cycle.
- Directed to a disabled lane (mask bit 6=0, in_sel=6): word consumed; drop_pulse=1 for exactly 1 cycle; out_valid stays 0.
- Assert rst_n=0 asynchronously mid-HOLD: out_valid=0 immediately; after release, the first round-robin word goes to lane 0.
- With DEMUX_SCHED_STATS_EN: 70000 transfers on lane 1 give lane_cnt[1] = 70000 mod 65536 = 4464; other counters 0.
